// File: rtl/snake_pkg.sv
// Shared board constants for the snake game and the frame-rate divider helper.
package snake_pkg;

    localparam int unsigned CLK_HZ_BOARD = 100_000_000;
    localparam int unsigned FPS_HZ_GAME  = 10;

    // clk cycles per FPS half-period; rounds down and never drops below 1
    function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                                input int unsigned fps_hz);
        int unsigned h;
        if (fps_hz == 0) return 1;
        h = clk_hz / (2 * fps_hz);
        return (h == 0) ? 1 : h;
    endfunction

endpackage

// File: rtl/clk_fps_if.sv
// Frame-rate outputs: the divided clock FPS and its clk-domain rising-edge strobe.
interface clk_fps_if;

    logic FPS;
    logic fps_tick;

    modport master (output FPS, output fps_tick);
    modport slave  (input  FPS, input  fps_tick);

endinterface

// File: rtl/clk_fps.sv
// Divides clk down to the game frame clock FPS (50% duty) and a one-cycle fps_tick
// strobe that marks each FPS rise for logic that stays in the clk domain.
module clk_fps
    import snake_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_BOARD,
    parameter int unsigned FPS_HZ = FPS_HZ_GAME
) (
    input  logic      clk,
    input  logic      rst,
    clk_fps_if.master frame
);

    localparam int unsigned HALF = half_cycles(CLK_HZ, FPS_HZ);
    localparam int unsigned CW   = $clog2(HALF) + 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    if (FPS_HZ == 0 || 2 * FPS_HZ > CLK_HZ) begin : g_bad_ratio
        $error("clk_fps: FPS_HZ must be nonzero and at most CLK_HZ/2");
    end

    logic [CW-1:0] cnt;
    logic          fps;
    logic          tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            fps  <= 1'b0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            fps  <= ~fps;
            // strobe only on the 0->1 toggle, landing in the same cycle FPS rises
            tick <= ~fps;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

    assign frame.FPS      = fps;
    assign frame.fps_tick = tick;

endmodule

// File: tb/tb_clk_fps.sv
// Self-checking bench for clk_fps: three ratios (HALF=5, 1, 6) against an
// arithmetic model of phase-since-reset, with random asynchronous resets.
module tb_clk_fps;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    clk_fps_if if_a ();
    clk_fps_if if_b ();
    clk_fps_if if_c ();

    clk_fps #(.CLK_HZ(20), .FPS_HZ(2)) dut_a (.clk(clk), .rst(rst), .frame(if_a.master));
    clk_fps #(.CLK_HZ(2),  .FPS_HZ(1)) dut_b (.clk(clk), .rst(rst), .frame(if_b.master));
    clk_fps #(.CLK_HZ(25), .FPS_HZ(2)) dut_c (.clk(clk), .rst(rst), .frame(if_c.master));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Posedges since reset released; everything else follows from it arithmetically.
    int n = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    function automatic logic exp_fps(input int k, input int h);
        return ((k / h) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int k, input int h);
        return (k >= h) && (((k - h) % (2 * h)) == 0);
    endfunction

    // Downstream consumer clocked directly on FPS
    logic [5:0] frames = '0;
    always @(posedge if_a.FPS or posedge rst) begin
        if (rst) frames <= '0;
        else     frames <= frames + 6'd1;
    end

    always @(negedge clk) begin
        check("fps_h5",   32'(if_a.FPS),      32'(exp_fps(n, 5)));
        check("tick_h5",  32'(if_a.fps_tick), 32'(exp_tick(n, 5)));
        check("fps_h1",   32'(if_b.FPS),      32'(exp_fps(n, 1)));
        check("tick_h1",  32'(if_b.fps_tick), 32'(exp_tick(n, 1)));
        check("fps_h6",   32'(if_c.FPS),      32'(exp_fps(n, 6)));
        check("tick_h6",  32'(if_c.fps_tick), 32'(exp_tick(n, 6)));
        check("frames",   32'(frames),        32'(((n + 5) / 10) % 64));
    end

    task automatic apply_reset(input int hold);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_fps_h5",  32'(if_a.FPS),      32'd0);
        check("async_tick_h5", 32'(if_a.fps_tick), 32'd0);
        check("async_fps_h1",  32'(if_b.FPS),      32'd0);
        check("async_fps_h6",  32'(if_c.FPS),      32'd0);
        repeat (hold) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int rises;
        int ticks;
        int aligned;
        logic prev;
        logic found;

        // Power-on reset for 3 cycles, released between edges
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // Periodicity over 100 cycles
        rises = 0; ticks = 0; aligned = 0; prev = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (if_a.FPS && !prev) rises++;
            if (if_a.fps_tick) begin
                ticks++;
                if (if_a.FPS && !prev) aligned++;
            end
            prev = if_a.FPS;
        end
        check("rises_100", 32'(rises),   32'd10);
        check("ticks_100", 32'(ticks),   32'd10);
        check("tick_algn", 32'(aligned), 32'd10);

        // Reset three cycles after an FPS rise
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (if_a.fps_tick) found = 1'b1;
        end
        check("rise_seen", 32'(found), 32'd1);
        repeat (2) @(posedge clk);
        apply_reset(1);
        repeat (20) @(posedge clk);

        // Random run lengths and reset hold times
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(1, 40)) @(posedge clk);
            apply_reset($urandom_range(1, 3));
        end
        repeat (70) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
